// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester and BRAM bus bundle for bram_port_arbiter
//
// Purpose: groups the three requester channels and the single BRAM port
// that the arbiter multiplexes.
// Ports (signals):
//   i_req/o_gnt       3-bit request / one-hot registered grant
//   i_acc/i_we        3-bit access strobe and write flag per requester
//   i_addrN/i_wdataN  per-requester address and write data (N = 0..2)
//   o_rvalid/o_rdata  one-hot read return and read data
//   o_mem_*           BRAM enable, write enable, address, write data
//   i_mem_rdata       BRAM read data (1-cycle latency)
// Modports: slave = arbiter side, master = requesters plus BRAM side.
interface bram_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic [2:0]    i_req;
  logic [2:0]    o_gnt;
  logic [2:0]    i_acc;
  logic [2:0]    i_we;
  logic [AW-1:0] i_addr0;
  logic [AW-1:0] i_addr1;
  logic [AW-1:0] i_addr2;
  logic [DW-1:0] i_wdata0;
  logic [DW-1:0] i_wdata1;
  logic [DW-1:0] i_wdata2;
  logic [2:0]    o_rvalid;
  logic [DW-1:0] o_rdata;
  logic          o_mem_en;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_req, i_acc, i_we,
    input  i_addr0, i_addr1, i_addr2,
    input  i_wdata0, i_wdata1, i_wdata2,
    input  i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_acc, i_we,
    output i_addr0, i_addr1, i_addr2,
    output i_wdata0, i_wdata1, i_wdata2,
    output i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - locked round-robin arbiter for the frame record BRAM port
//
// Purpose: grants the single BRAM port to one of three requesters using a
// locked round-robin scheme with a hold timeout, and returns read data to
// whichever requester issued the read.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    bram_port_arbiter_if.slave: requester channels and BRAM port
// Parameters: AW address width, DW data width, HOLD_MAX hold timeout
// (0 disables the timeout).
module bram_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int HOLD_MAX = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  bram_port_arbiter_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_MAX);
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;

  logic [1:0]    state;
  logic [1:0]    last;
  logic [CW-1:0] hold_cnt;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;

  logic [1:0]    owner;
  logic          own_acc;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          others_wait;
  logic          revoke;
  logic          pick_found;
  logic [1:0]    pick_idx;

  // Position `step` places after `base` in the 0,1,2 ring.
  function automatic logic [1:0] rr_pos(input logic [1:0] base, input int step);
    int s;
    s = (int'(base) + step) % 3;
    return 2'(s);
  endfunction

  always_comb begin
    owner = 2'd0;
    if (gnt[1]) owner = 2'd1;
    if (gnt[2]) owner = 2'd2;
  end

  // Owner mux; everything is forced to zero outside GRANT so that
  // stray strobes from non-owners never reach the BRAM.
  always_comb begin
    own_acc   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    if (state == GRANT) begin
      own_acc = bus.i_acc[owner];
      own_we  = bus.i_we[owner];
      case (owner)
        2'd1: begin
          own_addr  = bus.i_addr1;
          own_wdata = bus.i_wdata1;
        end
        2'd2: begin
          own_addr  = bus.i_addr2;
          own_wdata = bus.i_wdata2;
        end
        default: begin
          own_addr  = bus.i_addr0;
          own_wdata = bus.i_wdata0;
        end
      endcase
    end
  end

  // Search last+1, last+2, last; iterating downward lets the nearest
  // requester overwrite farther ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last;
    for (int k = 3; k >= 1; k--) begin
      if (bus.i_req[rr_pos(last, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_pos(last, k);
      end
    end
  end

  assign others_wait = |(bus.i_req & ~gnt);
  assign revoke      = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST) && others_wait;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      last     <= 2'd2;
      hold_cnt <= '0;
      gnt      <= 3'b000;
      rvalid   <= 3'b000;
    end else begin
      // Read return follows the access by one cycle regardless of what
      // happens to the grant in between.
      rvalid <= (own_acc && !own_we) ? gnt : 3'b000;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= 3'b001 << pick_idx;
            last     <= pick_idx;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          if (!bus.i_req[owner] || revoke) begin
            gnt   <= 3'b000;
            state <= TURN;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          gnt   <= 3'b000;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rvalid    = rvalid;
  assign bus.o_rdata     = bus.i_mem_rdata;
  assign bus.o_mem_en    = own_acc;
  assign bus.o_mem_we    = own_acc & own_we;
  assign bus.o_mem_addr  = own_addr;
  assign bus.o_mem_wdata = own_wdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard testbench for bram_port_arbiter
module tb_bram_port_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  bram_port_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical BRAM seen by the DUT.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) bram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else rdata_q <= bram[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_rdata = rdata_q;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_owner;
  bit m_turn;
  int m_held;
  int m_last;

  typedef struct {
    int            due;
    logic [2:0]    rv;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_turn  = 1'b0;
    m_held  = 0;
    m_last  = 2;
    q.delete();
  endfunction

  function automatic logic [AW-1:0] req_addr(int n);
    if (n == 0) return bus.i_addr0;
    if (n == 1) return bus.i_addr1;
    return bus.i_addr2;
  endfunction

  function automatic logic [DW-1:0] req_wdata(int n);
    if (n == 0) return bus.i_wdata0;
    if (n == 1) return bus.i_wdata1;
    return bus.i_wdata2;
  endfunction

  // One clock: check this cycle's outputs against the model at the
  // falling edge, advance the model, return 1 time unit after the rise.
  task automatic cycle();
    logic [2:0]    e_gnt;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    req;
    exp_t          e;
    @(negedge clk);
    e_gnt = 3'b000; e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (m_owner >= 0) begin
      e_gnt   = 3'b001 << m_owner;
      e_en    = bus.i_acc[m_owner];
      e_we    = e_en & bus.i_we[m_owner];
      e_addr  = req_addr(m_owner);
      e_wdata = req_wdata(m_owner);
    end
    chk("gnt", 32'(bus.o_gnt), 32'(e_gnt));
    chk("mem_en", 32'(bus.o_mem_en), 32'(e_en));
    chk("mem_we", 32'(bus.o_mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.o_mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(e_wdata));
    if (e_en && !e_we) begin
      e.due = cyc + 1; e.rv = e_gnt; e.data = ref_mem[e_addr];
      q.push_back(e);
    end
    if (e_we) ref_mem[e_addr] = e_wdata;

    req = bus.i_req;
    if (m_owner >= 0) begin
      bit others;
      others = |(req & ~(3'b001 << m_owner));
      if (!req[m_owner] || (HOLD > 0 && m_held == HOLD - 1 && others)) begin
        m_owner = -1;
        m_turn  = 1'b1;
      end else if (m_held < HOLD) begin
        m_held++;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (req != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (req[c]) begin
          m_owner = c; m_last = c; m_held = 0;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Read-return monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid", 32'(bus.o_rvalid), 32'(e.rv));
        chk("rdata", 32'(bus.o_rdata), 32'(e.data));
      end else begin
        chk("rvalid_idle", 32'(bus.o_rvalid), 32'h0);
      end
    end
  end

  task automatic wait_gnt(logic [2:0] want, string name);
    int n;
    n = 0;
    while (bus.o_gnt !== want && n < 12) begin
      cycle();
      n++;
    end
    if (bus.o_gnt !== want) chk(name, 32'(bus.o_gnt), 32'(want));
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.i_req = 3'b000; bus.i_acc = 3'b000; bus.i_we = 3'b000;
    bus.i_addr0 = '0; bus.i_addr1 = '0; bus.i_addr2 = '0;
    bus.i_wdata0 = '0; bus.i_wdata1 = '0; bus.i_wdata2 = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      bram[i] = v; ref_mem[i] = v;
    end
    bram[5] = 8'h83; ref_mem[5] = 8'h83;
    rdata_q = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_gnt", 32'(bus.o_gnt), 32'h0);
    chk("reset_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("reset_mem_en", 32'(bus.o_mem_en), 32'h0);

    // Round-robin order R0, R1, R2 with all requesting.
    bus.i_req = 3'b111;
    cycle();
    chk("first_grant", 32'(bus.o_gnt), 32'h1);
    bus.i_req = 3'b110;
    repeat (3) cycle();
    chk("second_grant", 32'(bus.o_gnt), 32'h2);
    bus.i_req = 3'b100;
    repeat (3) cycle();
    chk("third_grant", 32'(bus.o_gnt), 32'h4);
    bus.i_req = 3'b000;
    repeat (3) cycle();

    // R2 read of 0x005, dropping its request on the access cycle;
    // ungranted R0 strobes meanwhile.
    bus.i_req = 3'b100; bus.i_acc = 3'b101; bus.i_we = 3'b000; bus.i_addr2 = 10'h005;
    wait_gnt(3'b100, "r2_grant_timeout");
    bus.i_req = 3'b000;
    cycle();
    chk("read_rvalid", 32'(bus.o_rvalid), 32'h4);
    chk("read_rdata", 32'(bus.o_rdata), 32'h83);
    bus.i_acc = 3'b000;
    repeat (3) cycle();

    // R0 writes 0xFF to 0x000 and 0x001, then reads 0x001.
    bus.i_req = 3'b001; bus.i_acc = 3'b001; bus.i_we = 3'b001;
    bus.i_addr0 = 10'h000; bus.i_wdata0 = 8'hFF;
    wait_gnt(3'b001, "r0_grant_timeout");
    cycle();
    bus.i_addr0 = 10'h001;
    cycle();
    bus.i_we = 3'b000;
    cycle();
    chk("wr_read_rvalid", 32'(bus.o_rvalid), 32'h1);
    chk("wr_read_rdata", 32'(bus.o_rdata), 32'hFF);
    bus.i_req = 3'b000; bus.i_acc = 3'b000;
    repeat (3) cycle();

    // Hold timeout: R1 holds, R2 arrives in grant cycle 1.
    bus.i_req = 3'b010;
    wait_gnt(3'b010, "r1_grant_timeout");
    bus.i_req = 3'b110;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.o_gnt !== 3'b010) break;
      n++;
    end
    chk("hold_cycles", 32'(n), 32'd4);
    n = 0;
    while (bus.o_gnt === 3'b000 && n < 12) begin
      cycle();
      n++;
    end
    chk("after_revoke", 32'(bus.o_gnt), 32'h4);
    bus.i_req = 3'b000;
    repeat (3) cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 3) == 0) bus.i_req[b] = ~bus.i_req[b];
      bus.i_acc = 3'($urandom);
      bus.i_we  = 3'($urandom);
      bus.i_addr0 = AW'($urandom_range(0, 15));
      bus.i_addr1 = AW'($urandom_range(0, 15));
      bus.i_addr2 = AW'($urandom_range(0, 15));
      bus.i_wdata0 = DW'($urandom);
      bus.i_wdata1 = DW'($urandom);
      bus.i_wdata2 = DW'($urandom);
      cycle();
    end

    // Asynchronous reset in the middle of a granted read.
    bus.i_req = 3'b000; bus.i_acc = 3'b000;
    repeat (3) cycle();
    bus.i_req = 3'b001; bus.i_acc = 3'b001; bus.i_we = 3'b000;
    wait_gnt(3'b001, "rst_grant_timeout");
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(bus.o_gnt), 32'h0);
    chk("async_rst_mem_en", 32'(bus.o_mem_en), 32'h0);
    chk("async_rst_rvalid", 32'(bus.o_rvalid), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_req = 3'b111; bus.i_acc = 3'b000;
    cycle();
    chk("post_rst_grant", 32'(bus.o_gnt), 32'h1);
    bus.i_req = 3'b000;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Arbitrates the single port of the 1024x8 frame record BRAM between three requesters: the control-field set writer (R0), the checksum calculator scs (R1) and the frame send reader (R2).
- Replaces the OR-combined address, write-enable and write-data buses in the packet handler with a grant-based multiplexer.
- Uses locked round-robin grants with a hold-timeout so that no requester can starve the others.

Parameters:
- AW, 10, BRAM address width.
- DW, 8, BRAM data width.
- HOLD_MAX, 64, maximum consecutive granted cycles while another requester waits; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req  in  3  per-requester request; bit n belongs to Rn.
- o_gnt  out  3  one-hot grant, registered.
- i_acc  in  3  per-requester access strobe; only valid while granted.
- i_we  in  3  per-requester write flag, qualified by i_acc.
- i_addr0, i_addr1, i_addr2  in  AW each  per-requester address.
- i_wdata0, i_wdata1, i_wdata2  in  DW each  per-requester write data.
- o_rvalid  out  3  read-data-valid, one-hot, registered.
- o_rdata  out  DW  read data, driven directly from i_mem_rdata.
- o_mem_en  out  1  BRAM enable.
- o_mem_we  out  1  BRAM write enable.
- o_mem_addr  out  AW  BRAM address.
- o_mem_wdata  out  DW  BRAM write data.
- i_mem_rdata  in  DW  BRAM output data; 1-cycle read latency.

Behaviour:
- Reset (asynchronous, any time including mid-transfer):
  - o_gnt=0, o_rvalid=0, state=IDLE, hold counter=0.
  - Round-robin pointer last=2, so R0 has top priority at the first arbitration.
  - Memory outputs go to 0 combinationally because no grant is active.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If any i_req bit is set, select the first requesting index searching last+1, last+2, last (mod 3).
  - Set o_gnt one-hot for that index, set last to that index, clear the counter, go to GRANT.
  - Grant appears 1 cycle after the request is sampled.
- GRANT:
  - Memory port is a combinational mux of the owner's signals.
  - o_mem_en = i_acc[owner]; o_mem_we = i_acc[owner] & i_we[owner]; o_mem_addr / o_mem_wdata come from the owner.
  - The counter increments every cycle and saturates at HOLD_MAX.
  - Release: if i_req[owner] is low, o_gnt clears on the next edge and the state goes to TURN.
  - Revoke: if HOLD_MAX != 0, the counter equals HOLD_MAX-1, and any other i_req bit is set, o_gnt clears on the next edge and the state goes to TURN even though the owner still requests.
  - A revoked owner that keeps requesting re-competes in round-robin order.
- TURN:
  - One dead cycle: o_mem_en=0, no grant.
  - Go to IDLE unconditionally.
  - Minimum gap between two grants is therefore 2 cycles (TURN, then IDLE arbitration).
- Not granted: i_acc, i_we, i_addr and i_wdata of non-owners are ignored; no memory access results.
- When not in GRANT: o_mem_en, o_mem_we, o_mem_addr and o_mem_wdata are all 0.
- Read return:
  - A cycle with o_mem_en=1 and o_mem_we=0 sets o_rvalid[owner]=1 on the next cycle for exactly 1 cycle.
  - o_rdata is valid in that cycle.
  - The return is delivered even if the grant was released or revoked in between.
  - Writes never produce o_rvalid.
- Simultaneous requests: exactly one grant, chosen by the round-robin order. o_gnt is never multi-hot.
- A request that drops during IDLE before being granted is not granted. Sampling is single-cycle: no latching.
- Back-to-back accesses: one access per cycle, full throughput while granted.

Test Plan:
- Reset, then i_req=3'b111 held -> o_gnt=001 one cycle later. Drop i_req[0] -> o_gnt=000 (TURN, then IDLE), then o_gnt=010. Drop i_req[1] -> o_gnt=100. Grant order is R0, R1, R2.
- R2 granted, i_acc[2]=1, i_we[2]=0, i_addr2=0x005 over a BRAM holding 0x83 -> o_mem_en=1, o_mem_addr=0x005. Next cycle o_rvalid=100, o_rdata=0x83.
- R0 granted, writes 0xFF to 0x000 and 0x001, then reads 0x001 -> o_mem_we high for two cycles. Read returns 0xFF with o_rvalid=001.
- HOLD_MAX=4: R1 holds i_req, R2 requests at grant cycle 1 -> o_gnt[1] drops after 4 granted cycles. Next grant goes to R2, not R1.
- R2 is granted and issues a read; i_req[2] drops in the same cycle -> o_rvalid[2] is still asserted next cycle. i_acc from ungranted R0 causes o_mem_en=0.
- Assert i_rst asynchronously mid-GRANT with i_acc=1 -> o_gnt=0, o_mem_en=0, o_rvalid=0 immediately. After release with i_req=111 -> R0 is granted first.
